line_window_buffer: RTL and testbench

Streaming 3x3 window generator and read responder for stencil operators. It accepts one pixel per cycle in raster order and keeps two previous image rows in line buffers. It assembles a 3x3 neighbourhood and serves it through a per-tap read-enable/read-data port array. The port array is the serving end of the `i_rd_en` / `i_rd_data` interface that `weighted_average` consumes, so the two modules connect port-for-port.

---
 rtl/line_window_buffer.sv | 122 ++++++++++++
 tb/tb_line_window_buffer.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/line_window_buffer.sv
// Streaming 3x3 window generator over two line buffers, with per-tap registered read port.
// Optional end-of-frame pulse enabled by HIR_WINDOW_FRAME_DONE_EN; frame_done is tied low otherwise.
module line_window_buffer #(
    parameter int WIDTH = 32,
    parameter int IMG_W = 16,
    parameter int IMG_H = 16
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        wr_en,
    input  logic [WIDTH-1:0]            wr_data,
    input  logic [2:0][2:0]             rd_en,
    output logic [2:0][2:0][WIDTH-1:0]  rd_data,
    output logic                        window_valid,
    output logic                        frame_done
);
    localparam int CW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
    localparam int RW = (IMG_H > 1) ? $clog2(IMG_H) : 1;
    localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);
    localparam logic [CW-1:0] COL_TWO  = CW'(2);
    localparam logic [RW-1:0] ROW_TWO  = RW'(2);

    logic [CW-1:0]               col_q, col_d;
    logic [RW-1:0]               row_q, row_d;
    logic [2:0][2:0][WIDTH-1:0]  win_q, win_d;
    logic [2:0][2:0][WIDTH-1:0]  rd_data_q, rd_data_d;
    logic                        window_valid_q, window_valid_d;
    logic [WIDTH-1:0]            line0_q [IMG_W];
    logic [WIDTH-1:0]            line0_d [IMG_W];
    logic [WIDTH-1:0]            line1_q [IMG_W];
    logic [WIDTH-1:0]            line1_d [IMG_W];

    always_comb begin
        col_d          = col_q;
        row_d          = row_q;
        win_d          = win_q;
        line0_d        = line0_q;
        line1_d        = line1_q;
        rd_data_d      = rd_data_q;
        window_valid_d = 1'b0;

        // Reads sample the window as it stood before this edge's shift.
        for (int i = 0; i < 3; i++) begin
            for (int j = 0; j < 3; j++) begin
                if (rd_en[i][j]) begin
                    rd_data_d[i][j] = win_q[i][j];
                end
            end
        end

        if (wr_en) begin
            for (int r = 0; r < 3; r++) begin
                win_d[r][0] = win_q[r][1];
                win_d[r][1] = win_q[r][2];
            end
            win_d[0][2]    = line0_q[col_q];
            win_d[1][2]    = line1_q[col_q];
            win_d[2][2]    = wr_data;
            line0_d[col_q] = line1_q[col_q];
            line1_d[col_q] = wr_data;
            window_valid_d = (row_q >= ROW_TWO) && (col_q >= COL_TWO);

            if (col_q == COL_LAST) begin
                col_d = '0;
                if (row_q == ROW_LAST) begin
                    row_d = '0;
                end else begin
                    row_d = row_q + 1'b1;
                end
            end else begin
                col_d = col_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            col_q          <= '0;
            row_q          <= '0;
            win_q          <= '0;
            rd_data_q      <= '0;
            window_valid_q <= 1'b0;
        end else begin
            col_q          <= col_d;
            row_q          <= row_d;
            win_q          <= win_d;
            rd_data_q      <= rd_data_d;
            window_valid_q <= window_valid_d;
        end
    end

    // Line buffer contents are never cleared; window_valid gating hides stale rows.
    always_ff @(posedge clk) begin
        line0_q <= line0_d;
        line1_q <= line1_d;
    end

    assign rd_data      = rd_data_q;
    assign window_valid = window_valid_q;

`ifdef HIR_WINDOW_FRAME_DONE_EN
    logic frame_done_q, frame_done_d;

    always_comb begin
        frame_done_d = wr_en && (col_q == COL_LAST) && (row_q == ROW_LAST);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            frame_done_q <= 1'b0;
        end else begin
            frame_done_q <= frame_done_d;
        end
    end

    assign frame_done = frame_done_q;
`else
    assign frame_done = 1'b0;
`endif

endmodule

// File: tb/tb_line_window_buffer.sv
// Directed bench for line_window_buffer with a 4x4 image: vector table plus stall,
// mid-frame reset and back-to-back frame sequences.
module tb_line_window_buffer;
    localparam int W = 32;

`ifdef HIR_WINDOW_FRAME_DONE_EN
    localparam bit FD_ON = 1'b1;
`else
    localparam bit FD_ON = 1'b0;
`endif

    logic                    clk = 1'b0;
    logic                    rst;
    logic                    wr_en;
    logic [W-1:0]            wr_data;
    logic [2:0][2:0]         rd_en;
    logic [2:0][2:0][W-1:0]  rd_data;
    logic                    window_valid;
    logic                    frame_done;

    always #5 clk = ~clk;

    line_window_buffer #(.WIDTH(W), .IMG_W(4), .IMG_H(4)) dut (
        .clk          (clk),
        .rst          (rst),
        .wr_en        (wr_en),
        .wr_data      (wr_data),
        .rd_en        (rd_en),
        .rd_data      (rd_data),
        .window_valid (window_valid),
        .frame_done   (frame_done)
    );

    typedef struct {
        logic                    we;
        logic [W-1:0]            d;
        logic [2:0][2:0]         re;
        logic                    ev;
        logic                    efd;
        logic [2:0][2:0][W-1:0]  erd;
    } vec_t;

    vec_t tbl [18];
    int   nvec = 0;
    int   errs = 0;

    function automatic logic [2:0][2:0][W-1:0] w9(input int a, input int b, input int c,
                                                  input int d, input int e, input int f,
                                                  input int g, input int h, input int i);
        logic [2:0][2:0][W-1:0] x;
        x[0][0] = W'(a); x[0][1] = W'(b); x[0][2] = W'(c);
        x[1][0] = W'(d); x[1][1] = W'(e); x[1][2] = W'(f);
        x[2][0] = W'(g); x[2][1] = W'(h); x[2][2] = W'(i);
        return x;
    endfunction

    // Window expected after pixel p (1-based in frame) of a continuous 4-wide frame, offset by base.
    function automatic logic [2:0][2:0][W-1:0] win_of(input int p, input int base);
        logic [2:0][2:0][W-1:0] x;
        for (int r = 0; r < 3; r++)
            for (int c = 0; c < 3; c++)
                x[r][c] = W'(base + p - (2 - r) * 4 - (2 - c));
        return x;
    endfunction

    task automatic cyc(input logic we, input logic [W-1:0] d, input logic [2:0][2:0] re);
        wr_en   = we;
        wr_data = d;
        rd_en   = re;
        @(posedge clk);
        #1;
        nvec++;
    endtask

    task automatic chk_bit(input string nm, input logic act, input logic exp);
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %b, expected %b", nm, act, exp);
        end
    endtask

    task automatic chk_rd(input string nm, input logic [2:0][2:0][W-1:0] act,
                          input logic [2:0][2:0][W-1:0] exp);
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    task automatic run_table(input string tag);
        for (int i = 0; i < 18; i++) begin
            cyc(tbl[i].we, tbl[i].d, tbl[i].re);
            chk_bit($sformatf("%s[%0d] window_valid", tag, i), window_valid, tbl[i].ev);
            chk_bit($sformatf("%s[%0d] frame_done", tag, i), frame_done, tbl[i].efd);
            chk_rd($sformatf("%s[%0d] rd_data", tag, i), rd_data, tbl[i].erd);
        end
    endtask

    initial begin
        logic [2:0][2:0][W-1:0] hold;
        logic                   prev_v;
        int                     q;

        // Full frame 1..16 with a partial read in the pixel-11 pulse and a
        // full read in the pixel-16 pulse.
        for (int i = 0; i < 16; i++)
            tbl[i] = '{we: 1'b1, d: W'(i + 1), re: '0, ev: 1'b0, efd: 1'b0, erd: '0};
        tbl[10].ev = 1'b1;
        tbl[11].ev = 1'b1;
        tbl[11].re[1][1]  = 1'b1;
        tbl[11].erd[1][1] = W'(6);
        tbl[12].re  = '1;
        tbl[12].erd = w9(2, 3, 4, 6, 7, 8, 10, 11, 12);
        tbl[13].erd = tbl[12].erd;
        tbl[14].erd = tbl[12].erd;
        tbl[14].ev  = 1'b1;
        tbl[15].erd = tbl[12].erd;
        tbl[15].ev  = 1'b1;
        tbl[15].efd = FD_ON;
        tbl[16] = '{we: 1'b0, d: '0, re: '1, ev: 1'b0, efd: 1'b0,
                    erd: w9(6, 7, 8, 10, 11, 12, 14, 15, 16)};
        tbl[17] = '{we: 1'b0, d: '0, re: '0, ev: 1'b0, efd: 1'b0, erd: tbl[16].erd};

        rst = 1'b1; wr_en = 1'b0; wr_data = '0; rd_en = '0;
        @(posedge clk);
        #1;
        chk_bit("reset window_valid", window_valid, 1'b0);
        chk_bit("reset frame_done", frame_done, 1'b0);
        chk_rd("reset rd_data", rd_data, '0);
        rst = 1'b0;

        run_table("full");

        // Stalled frame with values 101..116: three idle cycles after every pixel.
        hold = tbl[17].erd;
        for (int p = 1; p <= 16; p++) begin
            logic ev;
            ev = (p == 11) || (p == 12) || (p == 15) || (p == 16);
            cyc(1'b1, W'(100 + p), '0);
            chk_bit($sformatf("stall p%0d window_valid", p), window_valid, ev);
            chk_rd($sformatf("stall p%0d rd hold", p), rd_data, hold);
            for (int g = 0; g < 3; g++) begin
                cyc(1'b0, '0, (g == 0 && ev) ? 9'h1ff : 9'h000);
                chk_bit($sformatf("stall p%0d gap%0d window_valid", p, g), window_valid, 1'b0);
                if (g == 0 && ev) begin
                    hold = win_of(p, 100);
                    chk_rd($sformatf("stall p%0d read", p), rd_data, hold);
                end
            end
        end

        // Mid-frame reset after six pixels, then the full frame again.
        for (int p = 1; p <= 6; p++)
            cyc(1'b1, W'(200 + p), '0);
        rst = 1'b1;
        #1;
        chk_bit("midrst window_valid", window_valid, 1'b0);
        chk_bit("midrst frame_done", frame_done, 1'b0);
        chk_rd("midrst rd_data", rd_data, '0);
        #1;
        rst = 1'b0;
        run_table("after_rst");

        // Two frames back to back, reading all taps every cycle.
        prev_v = 1'b0;
        for (int p = 1; p <= 32; p++) begin
            q = (p - 1) % 16 + 1;
            cyc(1'b1, W'(p), '1);
            chk_bit($sformatf("b2b p%0d window_valid", p), window_valid,
                    (q == 11) || (q == 12) || (q == 15) || (q == 16));
            chk_bit($sformatf("b2b p%0d frame_done", p), frame_done,
                    FD_ON && (p == 16 || p == 32));
            if (prev_v)
                chk_rd($sformatf("b2b p%0d read", p - 1), rd_data, win_of(p - 1, 0));
            prev_v = window_valid;
        end
        cyc(1'b0, '0, '1);
        chk_rd("b2b p32 read", rd_data, win_of(32, 0));
        chk_bit("b2b idle window_valid", window_valid, 1'b0);
        chk_bit("b2b idle frame_done", frame_done, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, errs);
        $finish;
    end

endmodule
